// File: rtl/piece_queue.sv
// Two-bag circular piece buffer between the 7-bag generator and the game FSM.
// Optional hold slot is compiled in when PIECE_QUEUE_HOLD_EN is defined.
module piece_queue #(
    parameter int unsigned PREVIEW = 3
) (
    input  logic                 clk,
    input  logic                 iReset,
    input  logic                 iRequest,
    input  logic                 iGenDone,
    input  logic [20:0]          iPieceOrder,
`ifdef PIECE_QUEUE_HOLD_EN
    input  logic                 iHold,
    output logic [2:0]           oHeld,
`endif
    output logic                 oGenEn,
    output logic [2:0]           oPiece,
    output logic                 oPieceValid,
    output logic [3*PREVIEW-1:0] oPreview,
    output logic [3:0]           oCount,
    output logic                 oReady,
    output logic                 oUnderflow
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_GEN  = 1'b1;

    function automatic logic [3:0] wrap14(input logic [4:0] x);
        return (x >= 5'd14) ? 4'(x - 5'd14) : x[3:0];
    endfunction

    logic       state_q, state_d;
    logic       gen_en_q, gen_en_d;
    logic [3:0] head_q, head_d;
    logic [3:0] count_q, count_d;
    logic [2:0] piece_q, piece_d;
    logic       valid_q, valid_d;
    logic       underflow_q, underflow_d;
    logic [2:0] buf_q [14];
    logic [3:0] tail;
    logic       pop_req;
    logic       pop;
    logic       load;

`ifdef PIECE_QUEUE_HOLD_EN
    logic [2:0] held_q, held_d;
    logic       hold_used_q, hold_used_d;
    logic       hold_act, hold_pop, hold_swap;
`endif

    // Tail is taken before any same-cycle pop so a load lands behind the old contents.
    assign tail = wrap14({1'b0, head_q} + {1'b0, count_q});
    assign load = gen_en_q & iGenDone;

    always_comb begin
        pop_req = iRequest;
`ifdef PIECE_QUEUE_HOLD_EN
        hold_act  = iHold & ~iRequest & ~hold_used_q & (piece_q != 3'd0);
        hold_pop  = hold_act & (held_q == 3'd0);
        hold_swap = hold_act & (held_q != 3'd0);
        pop_req   = iRequest | hold_pop;
`endif
        pop = pop_req & (count_q != 4'd0);
    end

    always_comb begin
        state_d     = state_q;
        gen_en_d    = gen_en_q;
        head_d      = head_q;
        count_d     = count_q;
        piece_d     = piece_q;
        valid_d     = 1'b0;
        underflow_d = underflow_q;

        if (state_q == S_IDLE) begin
            if (count_q <= 4'd7) begin
                state_d  = S_GEN;
                gen_en_d = 1'b1;
            end
        end else if (iGenDone) begin
            state_d  = S_IDLE;
            gen_en_d = 1'b0;
        end

        if (pop) begin
            piece_d = buf_q[head_q];
            valid_d = 1'b1;
            head_d  = wrap14({1'b0, head_q} + 5'd1);
        end else if (pop_req) begin
            underflow_d = 1'b1;
        end

        case ({load, pop})
            2'b10:   count_d = count_q + 4'd7;
            2'b01:   count_d = count_q - 4'd1;
            2'b11:   count_d = count_q + 4'd6;
            default: count_d = count_q;
        endcase

`ifdef PIECE_QUEUE_HOLD_EN
        held_d      = held_q;
        hold_used_d = hold_used_q;
        if (hold_pop) begin
            held_d      = piece_q;
            hold_used_d = 1'b1;
        end
        if (hold_swap) begin
            piece_d     = held_q;
            held_d      = piece_q;
            valid_d     = 1'b1;
            hold_used_d = 1'b1;
        end
        if (iRequest & pop) begin
            hold_used_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            state_q     <= S_IDLE;
            gen_en_q    <= 1'b0;
            head_q      <= '0;
            count_q     <= '0;
            piece_q     <= '0;
            valid_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gen_en_q    <= gen_en_d;
            head_q      <= head_d;
            count_q     <= count_d;
            piece_q     <= piece_d;
            valid_q     <= valid_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef PIECE_QUEUE_HOLD_EN
    always_ff @(posedge clk) begin
        if (iReset) begin
            held_q      <= '0;
            hold_used_q <= 1'b0;
        end else begin
            held_q      <= held_d;
            hold_used_q <= hold_used_d;
        end
    end

    assign oHeld = held_q;
`endif

    // Buffer contents need no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int unsigned k = 0; k < 7; k++) begin
                buf_q[wrap14(5'(tail) + 5'(k))] <= iPieceOrder[3*k +: 3];
            end
        end
    end

    always_comb begin
        oPreview = '0;
        for (int unsigned j = 0; j < PREVIEW; j++) begin
            if (j < 32'(count_q)) begin
                oPreview[3*j +: 3] = buf_q[wrap14(5'(head_q) + 5'(j))];
            end
        end
    end

    assign oGenEn      = gen_en_q;
    assign oPiece      = piece_q;
    assign oPieceValid = valid_q;
    assign oCount      = count_q;
    assign oReady      = (32'(count_q) > PREVIEW);
    assign oUnderflow  = underflow_q;

endmodule

// File: tb/tb_piece_queue.sv
// Randomised bench for piece_queue: queue-level reference model plus directed scenarios.
module tb_piece_queue;

    localparam int unsigned P = 3;
    localparam int MODE_FIX  = 0;
    localparam int MODE_RAND = 1;
    localparam int MODE_MAN  = 2;
    localparam logic [20:0] FIXBAG = {3'd4, 3'd6, 3'd2, 3'd5, 3'd7, 3'd1, 3'd3};

    logic           clk = 1'b0;
    logic           iReset = 1'b1;
    logic           iRequest = 1'b0;
    logic           iGenDone = 1'b0;
    logic [20:0]    iPieceOrder = '0;
    logic           oGenEn, oPieceValid, oReady, oUnderflow;
    logic [2:0]     oPiece;
    logic [3:0]     oCount;
    logic [3*P-1:0] oPreview;
`ifdef PIECE_QUEUE_HOLD_EN
    logic           iHold = 1'b0;
    logic [2:0]     oHeld;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    piece_queue #(.PREVIEW(P)) dut (
        .clk         (clk),
        .iReset      (iReset),
        .iRequest    (iRequest),
        .iGenDone    (iGenDone),
        .iPieceOrder (iPieceOrder),
`ifdef PIECE_QUEUE_HOLD_EN
        .iHold       (iHold),
        .oHeld       (oHeld),
`endif
        .oGenEn      (oGenEn),
        .oPiece      (oPiece),
        .oPieceValid (oPieceValid),
        .oPreview    (oPreview),
        .oCount      (oCount),
        .oReady      (oReady),
        .oUnderflow  (oUnderflow)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is just a FIFO of piece values.
    int  mq[$];
    bit  m_gen = 0, m_valid = 0, m_uf = 0, chk_en = 0;
    int  m_piece = 0, m_held = 0, m_used = 0;

    always @(posedge clk) begin : model
        int pre, oldp;
        bit popreq, hact, popped;
        if (iReset) begin
            mq.delete();
            m_gen = 0; m_piece = 0; m_valid = 0; m_uf = 0;
            m_held = 0; m_used = 0; chk_en = 1;
        end else begin
            pre = mq.size(); oldp = m_piece; popped = 0; m_valid = 0;
            popreq = iRequest; hact = 0;
`ifdef PIECE_QUEUE_HOLD_EN
            hact = iHold && !iRequest && m_used == 0 && m_piece != 0;
            if (hact && m_held == 0) popreq = 1;
`endif
            if (popreq) begin
                if (pre > 0) begin
                    m_piece = mq.pop_front(); m_valid = 1; popped = 1;
                end else begin
                    m_uf = 1;
                end
            end
`ifdef PIECE_QUEUE_HOLD_EN
            if (hact) begin
                if (m_held == 0) m_held = oldp;
                else begin m_piece = m_held; m_held = oldp; m_valid = 1; end
                m_used = 1;
            end
            if (iRequest && popped) m_used = 0;
`endif
            if (m_gen) begin
                if (iGenDone) begin
                    for (int k = 0; k < 7; k++) mq.push_back(int'(iPieceOrder[3*k +: 3]));
                    m_gen = 0;
                end
            end else if (pre <= 7) begin
                m_gen = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("count", int'(oCount), mq.size());
            check("genEn", int'(oGenEn), int'(m_gen));
            check("piece", int'(oPiece), m_piece);
            check("valid", int'(oPieceValid), int'(m_valid));
            check("underflow", int'(oUnderflow), int'(m_uf));
            check("ready", int'(oReady), int'(mq.size() > P));
            for (int j = 0; j < P; j++)
                check($sformatf("preview%0d", j), int'(oPreview[3*j +: 3]), (j < mq.size()) ? mq[j] : 0);
`ifdef PIECE_QUEUE_HOLD_EN
            check("held", int'(oHeld), m_held);
`endif
        end
    end

    int mode = MODE_FIX;
    int gcnt = 0;
    int gdelay = 10;

    function automatic logic [20:0] rand_bag();
        int a[7];
        int r, t;
        logic [20:0] b;
        for (int i = 0; i < 7; i++) a[i] = i + 1;
        for (int i = 6; i > 0; i--) begin
            r = int'($urandom_range(0, i));
            t = a[i]; a[i] = a[r]; a[r] = t;
        end
        b = '0;
        for (int i = 0; i < 7; i++) b[3*i +: 3] = 3'(a[i]);
        return b;
    endfunction

    task automatic gen_step();
        if (iGenDone) begin
            iGenDone = 0; gcnt = 0;
        end else if (mode == MODE_MAN || !oGenEn) begin
            gcnt = 0;
        end else begin
            gcnt++;
            if (gcnt >= gdelay) begin
                iGenDone = 1;
                iPieceOrder = (mode == MODE_FIX) ? FIXBAG : rand_bag();
                if (mode == MODE_RAND) gdelay = int'($urandom_range(1, 12));
            end
        end
    endtask

    task automatic cyc(input bit r, input bit h, input bit rst);
        @(negedge clk);
        gen_step();
        iRequest = r;
        iReset = rst;
`ifdef PIECE_QUEUE_HOLD_EN
        iHold = h;
`else
        if (h) iRequest = r;
`endif
    endtask

    task automatic wait_count(input int target, input int budget);
        int n = 0;
        while (int'(oCount) != target && n < budget) begin
            cyc(0, 0, 0);
            n++;
        end
        check("wait_count", int'(oCount), target);
    endtask

    task automatic manual_load(input bit r);
        cyc(r, 0, 0);
        iGenDone = 1;
        iPieceOrder = rand_bag();
        cyc(0, 0, 0);
    endtask

    int got[14];
    int mask;

    initial begin
        // Reset and fill with the fixed bag
        mode = MODE_FIX; gdelay = 10;
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        check("rst_count", int'(oCount), 0);
        check("rst_genEn", int'(oGenEn), 0);
        check("rst_piece", int'(oPiece), 0);
        cyc(0, 0, 0);
        wait_count(14, 80);
        check("fill_ready", int'(oReady), 1);
        check("fill_preview", int'(oPreview[8:0]), int'(9'b111_001_011));

        // Fourteen spaced pops: each group of seven must be a permutation of 1..7
        mode = MODE_RAND;
        for (int i = 0; i < 14; i++) begin
            cyc(1, 0, 0);
            cyc(0, 0, 0);
            check("pop_valid", int'(oPieceValid), 1);
            got[i] = int'(oPiece);
            if (i == 6) check("count_at_7", int'(oCount), 7);
        end
        for (int b = 0; b < 2; b++) begin
            mask = 0;
            for (int i = 0; i < 7; i++) mask |= (1 << got[7*b + i]);
            check($sformatf("perm_bag%0d", b), mask, 'hFE);
        end

        // Simultaneous pop and load, then a load across the 13 -> 0 wrap
        mode = MODE_FIX; gdelay = 10;
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        wait_count(14, 80);
        mode = MODE_MAN;
        for (int i = 0; i < 7; i++) cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("gen_rearm", int'(oGenEn), 1);
        manual_load(1);
        check("simul_piece", int'(oPiece), 3);
        check("simul_count", int'(oCount), 13);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        manual_load(0);
        check("refill_count", int'(oCount), 14);
        for (int i = 0; i < 12; i++) cyc(1, 0, 0);
        cyc(0, 0, 0);
        manual_load(1);
        check("wrap_count", int'(oCount), 8);

        // Drain with the generator stalled, then request from empty
        for (int i = 0; i < 8; i++) cyc(1, 0, 0);
        cyc(0, 0, 0);
        check("drained", int'(oCount), 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        check("empty_valid", int'(oPieceValid), 0);
        check("empty_uf", int'(oUnderflow), 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0);
        check("uf_sticky", int'(oUnderflow), 1);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        check("uf_cleared", int'(oUnderflow), 0);

        // Reset partway through a bag
        mode = MODE_RAND; gdelay = 10;
        wait_count(7, 60);
        gdelay = 8;
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        check("midrst_count", int'(oCount), 0);
        check("midrst_genEn", int'(oGenEn), 0);
        check("midrst_piece", int'(oPiece), 0);
        wait_count(14, 100);

`ifdef PIECE_QUEUE_HOLD_EN
        mode = MODE_FIX; gdelay = 10;
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        wait_count(14, 80);
        mode = MODE_MAN;
        for (int i = 0; i < 5; i++) cyc(1, 0, 0);
        cyc(0, 0, 0);
        check("hold_pre", int'(oPiece), 2);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        check("hold1_held", int'(oHeld), 2);
        check("hold1_piece", int'(oPiece), 6);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        check("hold2_piece", int'(oPiece), 6);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        check("hold3_piece", int'(oPiece), 4);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
        check("swap_piece", int'(oPiece), 2);
        check("swap_held", int'(oHeld), 4);
`endif

        // Random traffic
        mode = MODE_RAND;
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 599) == 0);
        cyc(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
        $fatal(1, "timeout");
    end

endmodule
